// File: rtl/user_project_io_bridge.sv
// Per-channel bridge between fabric (FIN/FOUT) and user-project pins (UIN/UOUT) with BYPASS/REG/SYNC/EDGE modes.
// Optional macro USER_IO_EDGE_EN builds the rising-edge detector for mode 3; without it mode 3 behaves as SYNC.
module user_project_io_bridge #(
    parameter int NUM_CH      = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  UserCLK,
    input  logic                  RST,
    input  logic [2*NUM_CH-1:0]   ConfigBits,
    input  logic                  FREEZE,
    input  logic [NUM_CH-1:0]     UIN,
    output logic [NUM_CH-1:0]     UOUT,
    input  logic [NUM_CH-1:0]     FIN,
    output logic [NUM_CH-1:0]     FOUT
);
    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_REG    = 2'd1;
    localparam logic [1:0] MODE_SYNC   = 2'd2;

    logic [NUM_CH-1:0]                  uo_d, uo_q;
    logic [NUM_CH-1:0]                  ui_d, ui_q;
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_d, sync_q;
    logic [NUM_CH-1:0]                  sync_last;
    logic [NUM_CH-1:0]                  edge_pulse;

    // All flops sample every cycle, independent of mode and FREEZE, so a mode
    // change only re-steers the output mux.
    always_comb begin
        uo_d      = FIN;
        ui_d      = UIN;
        sync_d    = '0;
        sync_d[0] = UIN;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            uo_q   <= '0;
            ui_q   <= '0;
            sync_q <= '0;
        end else begin
            uo_q   <= uo_d;
            ui_q   <= ui_d;
            sync_q <= sync_d;
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

`ifdef USER_IO_EDGE_EN
    logic [NUM_CH-1:0] prev_d, prev_q;

    always_comb begin
        prev_d = sync_last;
    end

    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign edge_pulse = sync_last & ~prev_q;
`else
    assign edge_pulse = sync_last;
`endif

    always_comb begin
        UOUT = '0;
        FOUT = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (ConfigBits[2*i +: 2])
                MODE_BYPASS: begin
                    UOUT[i] = FIN[i];
                    FOUT[i] = UIN[i];
                end
                MODE_REG: begin
                    UOUT[i] = uo_q[i];
                    FOUT[i] = ui_q[i];
                end
                MODE_SYNC: begin
                    UOUT[i] = uo_q[i];
                    FOUT[i] = sync_last[i];
                end
                default: begin
                    UOUT[i] = uo_q[i];
                    FOUT[i] = edge_pulse[i];
                end
            endcase
        end
        // Freeze overrides every mode, including the combinational bypass.
        if (FREEZE) begin
            UOUT = '0;
            FOUT = '0;
        end
    end
endmodule

// File: tb/tb_user_project_io_bridge.sv
// Directed self-checking bench for user_project_io_bridge (SYNC_STAGES=2 and SYNC_STAGES=3 instances).
module tb_user_project_io_bridge;
    localparam int NUM_CH = 20;

    logic                UserCLK = 1'b0;
    logic                RST     = 1'b1;
    logic [2*NUM_CH-1:0] cfg     = {NUM_CH{2'b01}};
    logic                freeze  = 1'b0;
    logic [NUM_CH-1:0]   uin     = '0;
    logic [NUM_CH-1:0]   fin     = '0;
    logic [NUM_CH-1:0]   uout, fout, uout3, fout3;

    int checks   = 0;
    int failures = 0;

    always #5 UserCLK = ~UserCLK;

    user_project_io_bridge #(.NUM_CH(NUM_CH), .SYNC_STAGES(2)) u_dut (
        .UserCLK(UserCLK), .RST(RST), .ConfigBits(cfg), .FREEZE(freeze),
        .UIN(uin), .UOUT(uout), .FIN(fin), .FOUT(fout)
    );

    user_project_io_bridge #(.NUM_CH(NUM_CH), .SYNC_STAGES(3)) u_dut3 (
        .UserCLK(UserCLK), .RST(RST), .ConfigBits(cfg), .FREEZE(freeze),
        .UIN(uin), .UOUT(uout3), .FIN(fin), .FOUT(fout3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge UserCLK);
        #1;
    endtask

    task automatic set_mode(input int ch, input logic [1:0] m);
        cfg[2*ch +: 2] = m;
    endtask

    logic exp2, exp3;

    initial begin
        // Reset with all channels registered and FIN all ones
        fin = 20'hFFFFF;
        tick();
        check("rst_uout", uout, 0);
        check("rst_fout", fout, 0);
        tick();
        check("rst_uout3", uout3, 0);
        RST = 1'b0;
        tick();
        check("post_rst_uout", uout, 20'hFFFFF);
        check("post_rst_uout3", uout3, 20'hFFFFF);
        check("post_rst_fout", fout, 0);

        // Channel 3 bypass follows without a clock edge
        set_mode(3, 2'd0);
        #1;
        uin[3] = 1'b1;
        #1;
        check("byp_fout_hi", fout, 20'h00008);
        fin[3] = 1'b0;
        #1;
        check("byp_uout3_lo", uout[3], 0);
        uin[3] = 1'b0;
        #1;
        check("byp_fout_lo", fout, 0);
        fin = 20'hFFFFF;

        // Channel 5 in SYNC: 3-stage instance rises after edge 3, 2-stage after edge 2
        cfg = {NUM_CH{2'b01}};
        set_mode(5, 2'd2);
        repeat (4) tick();
        uin[5] = 1'b1;
        fin[5] = 1'b0;
        #1;
        check("sync_uout_hold", uout3[5], 1);
        tick();
        check("sync_e1_s3", fout3[5], 0);
        check("sync_e1_uout", uout3[5], 0);
        check("sync_e1_s2", fout[5], 0);
        tick();
        check("sync_e2_s3", fout3[5], 0);
        check("sync_e2_s2", fout[5], 1);
        tick();
        check("sync_e3_s3", fout3[5], 1);
        uin[5] = 1'b0;
        fin[5] = 1'b1;
        repeat (4) tick();
        check("sync_back_lo", fout3[5], 0);

        // Channel 0 in mode 3, UIN held high 10 cycles then released
        set_mode(0, 2'd3);
        repeat (5) tick();
        check("edge_idle", fout[0], 0);
        uin[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
`ifdef USER_IO_EDGE_EN
            exp2 = (k == 2);
            exp3 = (k == 3);
`else
            exp2 = (k >= 2 && k <= 11);
            exp3 = (k >= 3 && k <= 12);
`endif
            check($sformatf("edge_s2_k%0d", k), fout[0], exp2);
            check($sformatf("edge_s3_k%0d", k), fout3[0], exp3);
            if (k == 10) uin[0] = 1'b0;
        end

        // FREEZE over registered channels
        cfg = {NUM_CH{2'b01}};
        fin = 20'hAAAAA;
        uin = 20'hAAAAA;
        repeat (2) tick();
        check("pre_frz_fout", fout, 20'hAAAAA);
        freeze = 1'b1;
        #1;
        check("frz_uout_now", uout, 0);
        set_mode(3, 2'd0);
        #1;
        check("frz_bypass_fout", fout, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("frz_uout_k%0d", k), uout, 0);
            check($sformatf("frz_fout_k%0d", k), fout3, 0);
        end
        freeze = 1'b0;
        #1;
        check("unfrz_uout", uout, 20'hAAAAA);
        check("unfrz_fout", fout, 20'hAAAAA);
        check("unfrz_fout3", fout3, 20'hAAAAA);

        // Reset while channel 0 is mid-synchronisation in mode 3
        cfg = {NUM_CH{2'b01}};
        set_mode(0, 2'd3);
        uin = '0;
        repeat (5) tick();
        uin[0] = 1'b1;
        tick();
        RST = 1'b1;
        #1;
        check("mid_rst_fout", fout[0], 0);
        check("mid_rst_uout", uout, 0);
        repeat (2) begin
            tick();
            check("mid_rst_hold", fout[0], 0);
        end
        RST = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
`ifdef USER_IO_EDGE_EN
            exp2 = (k == 2);
`else
            exp2 = (k >= 2);
`endif
            check($sformatf("rel_edge_k%0d", k), fout[0], exp2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
